sys_mem_responder: RTL and testbench



---
 rtl/sys_bus_pkg.sv | 22 ++
 rtl/sys_mem_responder_if.sv | 48 ++++
 rtl/sys_wait_ctr.sv | 33 +++
 rtl/sys_mem_responder.sv | 116 +++++++++++
 tb/tb_sys_mem_responder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sys_bus_pkg.sv
// ----------------------------------------------------------------------------
// sys_bus_pkg
// Shared system-bus definitions used by the cache controller and the memory
// responder.
//   READ / WRITE    : encodings of SysRW
//   SYS_WAITSTATES  : default number of wait states inserted by the responder
//   state_e         : responder FSM state (IDLE, WAIT, DATA), 2 bits
// ----------------------------------------------------------------------------
package sys_bus_pkg;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam int SYS_WAITSTATES = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DATA = 2'd2
   } state_e;

endpackage

// File: rtl/sys_mem_responder_if.sv
// ----------------------------------------------------------------------------
// sys_mem_responder_if
// System bus between an initiator (master) and the memory responder (slave).
//   SysStrobe     : master -> slave, one-cycle request pulse
//   SysRW         : master -> slave, READ=1 / WRITE=0, qualified by SysStrobe
//   SysAddr       : master -> slave, word address, qualified by SysStrobe
//   SysDataIn     : master -> slave, write data, held from strobe through DATA
//   SysDataOut    : slave -> master, read data, 0 whenever SysDataOE=0
//   SysDataOE     : slave -> master, slave drives read data this cycle
//   SysReady      : slave -> master, data phase of the current transfer
//   Busy          : slave -> master, transfer in progress (WAIT or DATA)
//   ProtocolError : slave -> master, sticky, strobe seen while Busy
//   DbgState      : slave -> observer, current responder FSM state
//
// Handshake: there is no backpressure. The master issues a single-cycle
// SysStrobe only while Busy=0; the slave answers with exactly one SysReady
// cycle a fixed WAITSTATES+1 cycles after the strobe. A strobe while Busy=1
// is dropped and flagged on ProtocolError.
// ----------------------------------------------------------------------------
interface sys_mem_responder_if
   import sys_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);

   logic                  SysStrobe;
   logic                  SysRW;
   logic [ADDR_WIDTH-1:0] SysAddr;
   logic [DATA_WIDTH-1:0] SysDataIn;
   logic [DATA_WIDTH-1:0] SysDataOut;
   logic                  SysDataOE;
   logic                  SysReady;
   logic                  Busy;
   logic                  ProtocolError;
   state_e                DbgState;

   modport master (
      output SysStrobe, SysRW, SysAddr, SysDataIn,
      input  SysDataOut, SysDataOE, SysReady, Busy, ProtocolError, DbgState
   );

   modport slave (
      input  SysStrobe, SysRW, SysAddr, SysDataIn,
      output SysDataOut, SysDataOE, SysReady, Busy, ProtocolError, DbgState
   );

endinterface

// File: rtl/sys_wait_ctr.sv
// ----------------------------------------------------------------------------
// sys_wait_ctr
// 4-bit loadable down counter that times the wait states of a transfer. It
// counts down to zero and holds there.
//   Clk       : clock, rising edge
//   Reset     : synchronous active-high, clears the count
//   Load      : load LoadValue this cycle
//   LoadValue : value to load
//   Carry     : count is zero and no load is in progress
// ----------------------------------------------------------------------------
module sys_wait_ctr (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Load,
   input  logic [3:0] LoadValue,
   output logic       Carry
);

   logic [3:0] r_count;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count <= 4'd0;
      end else if (Load) begin
         r_count <= LoadValue;
      end else if (r_count != 4'd0) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign Carry = (r_count == 4'd0) && !Load;

endmodule

// File: rtl/sys_mem_responder.sv
// ----------------------------------------------------------------------------
// sys_mem_responder
// Main-memory responder behind the cache. Accepts a strobed request, waits
// WAITSTATES cycles, then performs one data-phase cycle against an internal
// word-addressed memory of 2**ADDR_WIDTH words.
//   Clk   : clock, rising edge
//   Reset : synchronous active-high; clears control state, not memory
//   bus   : sys_mem_responder_if slave (strobe/rw/addr/data in, data/oe/
//           ready/busy/error/state out)
// ----------------------------------------------------------------------------
module sys_mem_responder
   import sys_bus_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int WAITSTATES = SYS_WAITSTATES
) (
   input  logic                Clk,
   input  logic                Reset,
   sys_mem_responder_if.slave  bus
);

   if (WAITSTATES < 1 || WAITSTATES > 15) begin : g_bad_waitstates
      $error("sys_mem_responder: WAITSTATES must be within 1..15");
   end

   localparam logic [3:0] LP_LOAD = 4'(WAITSTATES - 1);

   state_e                r_state;
   logic                  r_rw;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_oe;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_perr;
   logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

   logic                  w_load;
   logic                  w_carry;

   assign w_load = (r_state == IDLE) && bus.SysStrobe;

   sys_wait_ctr u_wait_ctr (
      .Clk       (Clk),
      .Reset     (Reset),
      .Load      (w_load),
      .LoadValue (LP_LOAD),
      .Carry     (w_carry)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_rw       <= WRITE;
         r_addr     <= '0;
         r_data_out <= '0;
         r_oe       <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_perr     <= 1'b0;
      end else begin
         // A strobe outside IDLE is dropped; only the sticky flag records it.
         if (bus.SysStrobe && (r_state != IDLE)) begin
            r_perr <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (bus.SysStrobe) begin
                  r_rw    <= bus.SysRW;
                  r_addr  <= bus.SysAddr;
                  r_busy  <= 1'b1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_carry) begin
                  r_state <= DATA;
                  r_ready <= 1'b1;
                  // Read data is fetched on the way into DATA so it is
                  // presented straight from a register during the data phase.
                  if (r_rw == READ) begin
                     r_data_out <= r_mem[r_addr];
                     r_oe       <= 1'b1;
                  end
               end
            end
            DATA: begin
               r_state    <= IDLE;
               r_ready    <= 1'b0;
               r_oe       <= 1'b0;
               r_busy     <= 1'b0;
               r_data_out <= '0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Write commits on the edge that ends DATA; a Reset on that edge aborts it.
   always_ff @(posedge Clk) begin
      if (!Reset && (r_state == DATA) && (r_rw == WRITE)) begin
         r_mem[r_addr] <= bus.SysDataIn;
      end
   end

   assign bus.SysDataOut    = r_data_out;
   assign bus.SysDataOE     = r_oe;
   assign bus.SysReady      = r_ready;
   assign bus.Busy          = r_busy;
   assign bus.ProtocolError = r_perr;
   assign bus.DbgState      = r_state;

endmodule

// File: tb/tb_sys_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_sys_mem_responder
// Directed self-checking bench for sys_mem_responder with WAITSTATES=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "cycle n" is the interval following edge n.
// ----------------------------------------------------------------------------
module tb_sys_mem_responder;
   import sys_bus_pkg::*;

   localparam int WS = 2;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sys_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

   sys_mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .WAITSTATES (WS)
   ) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  32'(bus.Busy),      32'd0);
      check({tag, "_ready"}, 32'(bus.SysReady),  32'd0);
      check({tag, "_oe"},    32'(bus.SysDataOE), 32'd0);
      check({tag, "_dout"},  bus.SysDataOut,     32'd0);
   endtask

   // Full transfer starting in the current cycle; returns in cycle WS+2.
   task automatic do_xfer(input logic rw, input logic [9:0] addr, input logic [31:0] wdata);
      logic [31:0] exp_d;
      bus.SysStrobe = 1'b1;
      bus.SysRW     = rw;
      bus.SysAddr   = addr;
      bus.SysDataIn = wdata;
      step();
      bus.SysStrobe = 1'b0;
      for (int c = 1; c <= WS; c++) begin
         check("wait_busy",  32'(bus.Busy),      32'd1);
         check("wait_ready", 32'(bus.SysReady),  32'd0);
         check("wait_oe",    32'(bus.SysDataOE), 32'd0);
         step();
      end
      exp_d = 32'd0;
      if (rw == READ) begin
         if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
         end else begin
            exp_d = exp_q.pop_front();
         end
      end
      check("data_busy",  32'(bus.Busy),      32'd1);
      check("data_ready", 32'(bus.SysReady),  32'd1);
      check("data_oe",    32'(bus.SysDataOE), 32'(rw == READ));
      check("data_dout",  bus.SysDataOut,     exp_d);
      step();
      check_idle("after");
   endtask

   task automatic read_xfer(input logic [9:0] addr, input logic [31:0] exp_d);
      exp_q.push_back(exp_d);
      do_xfer(READ, addr, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst           = 1'b1;
      bus.SysStrobe = 1'b0;
      bus.SysRW     = WRITE;
      bus.SysAddr   = '0;
      bus.SysDataIn = '0;

      // Reset, then idle for 5 cycles
      do_reset();
      check("rst_state", 32'(bus.DbgState), 32'(IDLE));
      check("rst_perr",  32'(bus.ProtocolError), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check_idle("idle");
         step();
      end

      // Write then read of 0x005
      do_xfer(WRITE, 10'h005, 32'hDEADBEEF);
      read_xfer(10'h005, 32'hDEADBEEF);

      // Address extremes
      do_xfer(WRITE, 10'h000, 32'h11111111);
      do_xfer(WRITE, 10'h3FF, 32'h22222222);
      read_xfer(10'h000, 32'h11111111);
      read_xfer(10'h3FF, 32'h22222222);
      check("perr_clean", 32'(bus.ProtocolError), 32'd0);

      // Strobe in cycle 2 of a read; the stray request would clobber 0x3FF
      bus.SysStrobe = 1'b1; bus.SysRW = READ; bus.SysAddr = 10'h005;
      step();                                        // cycle 1
      bus.SysStrobe = 1'b0;
      step();                                        // cycle 2
      bus.SysStrobe = 1'b1; bus.SysRW = WRITE; bus.SysAddr = 10'h3FF;
      bus.SysDataIn = 32'h0BAD0BAD;
      check("pe_c2_perr", 32'(bus.ProtocolError), 32'd0);
      step();                                        // cycle 3
      bus.SysStrobe = 1'b0;
      check("pe_c3_ready", 32'(bus.SysReady),      32'd1);
      check("pe_c3_oe",    32'(bus.SysDataOE),     32'd1);
      check("pe_c3_dout",  bus.SysDataOut,         32'hDEADBEEF);
      check("pe_c3_perr",  32'(bus.ProtocolError), 32'd1);
      for (int c = 4; c <= 6; c++) begin
         step();
         check("pe_nobusy", 32'(bus.Busy),          32'd0);
         check("pe_sticky", 32'(bus.ProtocolError), 32'd1);
      end
      do_reset();
      check("pe_cleared", 32'(bus.ProtocolError), 32'd0);
      read_xfer(10'h3FF, 32'h22222222);

      // Reset during DATA aborts a write
      do_xfer(WRITE, 10'h010, 32'h00000000);
      bus.SysStrobe = 1'b1; bus.SysRW = WRITE; bus.SysAddr = 10'h010;
      bus.SysDataIn = 32'hCAFEF00D;
      step();                                        // cycle 1
      bus.SysStrobe = 1'b0;
      step();                                        // cycle 2
      step();                                        // cycle 3 (DATA)
      check("rd_c3_ready", 32'(bus.SysReady), 32'd1);
      rst = 1'b1;
      step();                                        // cycle 4
      check_idle("rd_c4");
      check("rd_c4_state", 32'(bus.DbgState), 32'(IDLE));
      rst = 1'b0;
      step();
      read_xfer(10'h010, 32'h00000000);

      // Strobe held high for 8 cycles of reads
      bus.SysRW = READ;
      bus.SysAddr = 10'h000;
      for (int c = 0; c <= 9; c++) begin
         bus.SysStrobe = (c <= 7);
         if (c == 4) bus.SysAddr = 10'h3FF;
         check("hold_ready", 32'(bus.SysReady), 32'((c == 3) || (c == 7)));
         check("hold_busy",  32'(bus.Busy),
               32'(((c >= 1) && (c <= 3)) || ((c >= 5) && (c <= 7))));
         if (c == 3) check("hold_d0", bus.SysDataOut, 32'h11111111);
         if (c == 7) check("hold_d1", bus.SysDataOut, 32'h22222222);
         step();
      end
      bus.SysStrobe = 1'b0;
      check("hold_perr", 32'(bus.ProtocolError), 32'd1);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
